// File: rtl/sd_frame_sched.sv
// SD-card raw video frame scheduler.
// Walks the sectors of one frame at a time and issues one SD sector read per
// sector into a ping-pong DDR bank. A new frame starts only after the pace
// interval has elapsed and the display has released the target bank.
// A sector that never completes is retried after a timeout. That retry also
// sets a sticky error flag, which only reset clears.
module sd_frame_sched #(
   parameter logic [31:0] ADDR0         = 32'd16640,
   parameter logic [31:0] ADDR1         = 32'd2978816,
   parameter logic [25:0] SEC_PER_FRAME = 26'd8168,
   parameter logic [15:0] NUM_FRAMES    = 16'd100,
   parameter logic [23:0] PACE_CYCLES   = 24'd1000000,
   parameter logic [23:0] TIMEOUT       = 24'd65535
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ddr_init_done,
   input  logic [1:0]  switch_video,
   input  logic        buf_free,
   input  logic        rd_busy,
   output logic        rd_start_en,
   output logic [31:0] rd_sec_addr,
   output logic        wr_bank,
   output logic        frame_done,
   output logic [15:0] frame_idx,
   output logic        timeout_err
);

   typedef enum logic [2:0] {
      S_IDLE, S_LATCH, S_START, S_WAIT, S_NEXT, S_FEND, S_PACE
   } state_t;

   state_t      state, state_nxt;
   logic        busy_d0, busy_d1;
   logic        sec_done;
   logic [1:0]  vid_sel;
   logic [31:0] base;
   logic [25:0] sec_cnt;
   logic [23:0] wait_cnt;
   logic [23:0] pace_cnt;
   logic        last_sec;
   logic        wait_expired;
   logic        pace_ok;
   logic        vid_changed;
   logic [31:0] vid_addr;
   logic [15:0] idx_eff;
   logic [31:0] base_nxt;

   // A sector is done when the synchronised busy line falls.
   assign sec_done     = busy_d1 & ~busy_d0;
   assign last_sec     = (sec_cnt == SEC_PER_FRAME - 26'd1);
   assign wait_expired = (wait_cnt == TIMEOUT);
   assign pace_ok      = (pace_cnt >= PACE_CYCLES - 24'd1);

   // Frame base for the frame about to be latched. A video change restarts at frame 0.
   assign vid_changed = (switch_video != vid_sel);
   assign vid_addr    = (switch_video == 2'b01) ? ADDR1 : ADDR0;
   assign idx_eff     = vid_changed ? 16'd0 : frame_idx;
   assign base_nxt    = vid_addr + 32'(idx_eff) * 32'(SEC_PER_FRAME);

   // Double-register the reader busy line into the clk domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_d0 <= 1'b0;
         busy_d1 <= 1'b0;
      end else begin
         busy_d0 <= rd_busy;
         busy_d1 <= busy_d0;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic. Completions outside WAIT are simply never looked at.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (ddr_init_done && buf_free) state_nxt = S_LATCH;
         S_LATCH: state_nxt = S_START;
         S_START: state_nxt = S_WAIT;
         S_WAIT: begin
            if (sec_done)          state_nxt = S_NEXT;
            else if (wait_expired) state_nxt = S_START;
         end
         S_NEXT:  state_nxt = last_sec ? S_FEND : S_START;
         S_FEND:  state_nxt = S_PACE;
         S_PACE:  if (pace_ok && buf_free && ddr_init_done) state_nxt = S_LATCH;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Moore outputs. The read address is derived from latched state only, so a
   // video switch mid-frame cannot disturb it.
   always_comb begin
      rd_start_en = (state == S_START);
      frame_done  = (state == S_FEND);
      rd_sec_addr = base + 32'(sec_cnt);
   end

   // Frame/sector datapath: base latch, sector/wait/pace counters, bank and index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vid_sel     <= 2'b00;
         base        <= 32'd0;
         sec_cnt     <= 26'd0;
         wait_cnt    <= 24'd0;
         pace_cnt    <= 24'd0;
         wr_bank     <= 1'b0;
         frame_idx   <= 16'd0;
         timeout_err <= 1'b0;
      end else begin
         // Pace counter free-runs from the last LATCH and saturates.
         if (pace_cnt != 24'hFF_FFFF) pace_cnt <= pace_cnt + 24'd1;
         unique case (state)
            S_LATCH: begin
               vid_sel  <= switch_video;
               if (vid_changed) frame_idx <= 16'd0;
               base     <= base_nxt;
               sec_cnt  <= 26'd0;
               pace_cnt <= 24'd0;
            end
            S_START: wait_cnt <= 24'd0;
            S_WAIT: begin
               if (!sec_done) begin
                  if (wait_expired) timeout_err <= 1'b1;
                  else              wait_cnt    <= wait_cnt + 24'd1;
               end
            end
            S_NEXT: if (!last_sec) sec_cnt <= sec_cnt + 26'd1;
            S_FEND: begin
               wr_bank   <= ~wr_bank;
               frame_idx <= (frame_idx == NUM_FRAMES - 16'd1) ? 16'd0 : frame_idx + 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_frame_sched.sv
// Directed bench for sd_frame_sched with a small SD reader model.
module tb_sd_frame_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ddr_init_done = 1'b0;
   logic [1:0]  switch_video = 2'b00;
   logic        buf_free = 1'b0;
   logic        rd_busy = 1'b0;
   logic        rd_start_en, wr_bank, frame_done, timeout_err;
   logic [31:0] rd_sec_addr;
   logic [15:0] frame_idx;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct { int cyc; int addr; int bank; int idx; } ev_t;
   ev_t starts[$];
   ev_t fstarts[$];
   logic new_frame = 1'b1;
   logic both_high = 1'b0;
   logic hang_arm  = 1'b0;
   logic hang_used = 1'b0;
   int   busy_cnt  = 0;

   always #5 clk = ~clk;

   sd_frame_sched #(
      .ADDR0(32'd100), .ADDR1(32'd5000), .SEC_PER_FRAME(26'd4),
      .NUM_FRAMES(16'd3), .PACE_CYCLES(24'd40), .TIMEOUT(24'd20)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ddr_init_done(ddr_init_done),
      .switch_video(switch_video), .buf_free(buf_free), .rd_busy(rd_busy),
      .rd_start_en(rd_start_en), .rd_sec_addr(rd_sec_addr), .wr_bank(wr_bank),
      .frame_done(frame_done), .frame_idx(frame_idx), .timeout_err(timeout_err)
   );

   // Reader model: busy rises after a start and falls 10 cycles later; once
   // armed, the first read of sector 101 hangs forever.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_busy  <= 1'b0;
         busy_cnt <= 0;
      end else if (rd_start_en) begin
         rd_busy <= 1'b1;
         if (hang_arm && !hang_used && rd_sec_addr == 32'd101) begin
            busy_cnt  <= 0;
            hang_used <= 1'b1;
         end else begin
            busy_cnt <= 10;
         end
      end else if (busy_cnt == 1) begin
         rd_busy  <= 1'b0;
         busy_cnt <= 0;
      end else if (busy_cnt > 1) begin
         busy_cnt <= busy_cnt - 1;
      end
   end

   // Record every start (and each frame's first start) just after the clock edge.
   always begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
         new_frame = 1'b1;
      end else begin
         if (rd_start_en) begin
            starts.push_back('{cyc, int'(rd_sec_addr), int'(wr_bank), int'(frame_idx)});
            if (new_frame) fstarts.push_back('{cyc, int'(rd_sec_addr), int'(wr_bank), int'(frame_idx)});
            new_frame = 1'b0;
         end
         if (frame_done) new_frame = 1'b1;
         if (rd_start_en && frame_done) both_high = 1'b1;
      end
   end

   task automatic wait_frame_done(input int bound, input string tag);
      int n = 0;
      do begin @(negedge clk); n++; end while (!frame_done && n < bound);
      if (!frame_done) begin
         checks++; errors++;
         $display("FAIL %s: frame_done not seen within %0d cycles", tag, bound);
      end
   endtask

   task automatic wait_start(input int bound, input int addr, input string tag);
      int n = 0;
      bit hit;
      do begin
         @(negedge clk); n++;
         hit = rd_start_en && (addr < 0 || int'(rd_sec_addr) == addr);
      end while (!hit && n < bound);
      if (!hit) begin
         checks++; errors++;
         $display("FAIL %s: start (addr %0d) not seen within %0d cycles", tag, addr, bound);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ddr_init_done = 1'b0; buf_free = 1'b0; switch_video = 2'b00;
      repeat (3) @(negedge clk);
      checks++; if (rd_start_en !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", rd_start_en); end
      checks++; if (rd_sec_addr !== 32'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", rd_sec_addr); end
      checks++; if (wr_bank !== 1'b0) begin errors++; $display("FAIL reset_bank: got %b want 0", wr_bank); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fdone: got %b want 0", frame_done); end
      checks++; if (frame_idx !== 16'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", frame_idx); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_terr: got %b want 0", timeout_err); end
   endtask

   task automatic test_bringup();
      int a;
      rst_n = 1'b1; buf_free = 1'b1; ddr_init_done = 1'b0;
      repeat (50) @(negedge clk);
      checks++; if (starts.size() != 0) begin errors++; $display("FAIL bringup_no_start: got %0d starts want 0", starts.size()); end
      ddr_init_done = 1'b1;
      wait_frame_done(300, "bringup");
      for (int i = 0; i < 4; i++) begin
         a = (i < starts.size()) ? starts[i].addr : -1;
         checks++; if (a != 100 + i) begin errors++; $display("FAIL bringup_addr%0d: got %0d want %0d", i, a, 100 + i); end
      end
      @(negedge clk);
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL bringup_fdone_width: got %b want 0", frame_done); end
      checks++; if (wr_bank !== 1'b1) begin errors++; $display("FAIL bringup_bank: got %b want 1", wr_bank); end
      checks++; if (frame_idx !== 16'd1) begin errors++; $display("FAIL bringup_idx: got %0d want 1", frame_idx); end
   endtask

   task automatic test_wrap();
      int exp_addr [4] = '{100, 104, 108, 100};
      int exp_bank [4] = '{0, 1, 0, 1};
      int exp_idx  [4] = '{0, 1, 2, 0};
      ev_t e;
      repeat (3) wait_frame_done(300, "wrap");
      for (int i = 0; i < 4; i++) begin
         e = (i < fstarts.size()) ? fstarts[i] : '{-1, -1, -1, -1};
         checks++; if (e.addr != exp_addr[i]) begin errors++; $display("FAIL wrap_addr%0d: got %0d want %0d", i, e.addr, exp_addr[i]); end
         checks++; if (e.bank != exp_bank[i]) begin errors++; $display("FAIL wrap_bank%0d: got %0d want %0d", i, e.bank, exp_bank[i]); end
         checks++; if (e.idx != exp_idx[i]) begin errors++; $display("FAIL wrap_idx%0d: got %0d want %0d", i, e.idx, exp_idx[i]); end
      end
      for (int i = 1; i < 4; i++) begin
         int gap = (i < fstarts.size()) ? fstarts[i].cyc - fstarts[i-1].cyc : -1;
         checks++; if (gap < 40) begin errors++; $display("FAIL wrap_spacing%0d: got %0d want >=40", i, gap); end
      end
   endtask

   task automatic test_switch();
      int n0 = starts.size();
      int a;
      wait_start(400, 106, "switch_sec2");
      switch_video = 2'b01;
      wait_frame_done(300, "switch");
      for (int i = 0; i < 4; i++) begin
         a = (n0 + i < starts.size()) ? starts[n0+i].addr : -1;
         checks++; if (a != 104 + i) begin errors++; $display("FAIL switch_addr%0d: got %0d want %0d", i, a, 104 + i); end
      end
      checks++; if (starts.size() != n0 + 4) begin errors++; $display("FAIL switch_count: got %0d want %0d", starts.size() - n0, 4); end
      wait_start(200, -1, "switch_next");
      checks++; if (rd_sec_addr !== 32'd5000) begin errors++; $display("FAIL switch_base: got %0d want 5000", rd_sec_addr); end
      checks++; if (frame_idx !== 16'd0) begin errors++; $display("FAIL switch_idx: got %0d want 0", frame_idx); end
   endtask

   task automatic test_timeout();
      int exp_addr [5] = '{100, 101, 101, 102, 103};
      int n0, a, gap;
      switch_video = 2'b00;
      hang_arm = 1'b1;
      wait_frame_done(300, "timeout_prev");
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_pre: got %b want 0", timeout_err); end
      n0 = starts.size();
      wait_frame_done(400, "timeout");
      for (int i = 0; i < 5; i++) begin
         a = (n0 + i < starts.size()) ? starts[n0+i].addr : -1;
         checks++; if (a != exp_addr[i]) begin errors++; $display("FAIL timeout_addr%0d: got %0d want %0d", i, a, exp_addr[i]); end
      end
      checks++; if (starts.size() != n0 + 5) begin errors++; $display("FAIL timeout_count: got %0d want 5", starts.size() - n0); end
      // Start, 1 cycle to WAIT, wait counter 0..20 over 21 WAIT cycles, then START.
      gap = (n0 + 2 < starts.size()) ? starts[n0+2].cyc - starts[n0+1].cyc : -1;
      checks++; if (gap != 22) begin errors++; $display("FAIL timeout_retry_gap: got %0d want 22", gap); end
      checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b want 1", timeout_err); end
   endtask

   task automatic test_backpressure_reset();
      int n0;
      buf_free = 1'b0;
      n0 = starts.size();
      repeat (100) @(negedge clk);
      checks++; if (starts.size() != n0) begin errors++; $display("FAIL bp_hold: got %0d starts want 0", starts.size() - n0); end
      buf_free = 1'b1;
      wait_start(50, -1, "bp_resume");
      checks++; if (rd_sec_addr !== 32'd104) begin errors++; $display("FAIL bp_addr: got %0d want 104", rd_sec_addr); end
      checks++; if (wr_bank !== 1'b1) begin errors++; $display("FAIL bp_bank: got %b want 1", wr_bank); end
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (rd_start_en !== 1'b0) begin errors++; $display("FAIL rst_start: got %b want 0", rd_start_en); end
      checks++; if (rd_sec_addr !== 32'd0) begin errors++; $display("FAIL rst_addr: got %0d want 0", rd_sec_addr); end
      checks++; if (wr_bank !== 1'b0) begin errors++; $display("FAIL rst_bank: got %b want 0", wr_bank); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_fdone: got %b want 0", frame_done); end
      checks++; if (frame_idx !== 16'd0) begin errors++; $display("FAIL rst_idx: got %0d want 0", frame_idx); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_terr: got %b want 0", timeout_err); end
      @(negedge clk);
      rst_n = 1'b1;
      wait_start(50, -1, "post_reset");
      checks++; if (rd_sec_addr !== 32'd100) begin errors++; $display("FAIL post_reset_addr: got %0d want 100", rd_sec_addr); end
      checks++; if (wr_bank !== 1'b0) begin errors++; $display("FAIL post_reset_bank: got %b want 0", wr_bank); end
      checks++; if (both_high !== 1'b0) begin errors++; $display("FAIL start_and_done_overlap: got %b want 0", both_high); end
   endtask

   initial begin
      test_reset();
      test_bringup();
      test_wrap();
      test_switch();
      test_timeout();
      test_backpressure_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
